// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: controller state
// encoding, default operand width and the ALU operation select codes.
package booth_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: picks the ALU operation from {Q[0], Q-1}, takes the
// ALU result (or keeps A), recovers the true sign of the exact add/sub result
// and performs the arithmetic right shift of {s, A', Q, Q-1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  input  logic             q1,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q1_next,
  output logic             alu_addsub
);

  logic [1:0]       pair;
  logic [WIDTH-1:0] a_sel;
  logic             ovf;
  logic             sign_in;

  assign pair = {q[0], q1};

  // Select A' and the shift-in sign; the ALU result is only trusted for 10/01,
  // and its MSB is corrected by the overflow flag so M = most-negative works
  always_comb begin
    alu_addsub = OP_ADD;
    a_sel      = a;
    ovf        = 1'b0;
    sign_in    = a[WIDTH-1];
    case (pair)
      2'b10: begin
        alu_addsub = OP_SUB;
        a_sel      = alu_result;
        ovf        = (a[WIDTH-1] != m[WIDTH-1]) & (alu_result[WIDTH-1] != a[WIDTH-1]);
        sign_in    = alu_result[WIDTH-1] ^ ovf;
      end
      2'b01: begin
        alu_addsub = OP_ADD;
        a_sel      = alu_result;
        ovf        = (a[WIDTH-1] == m[WIDTH-1]) & (alu_result[WIDTH-1] != a[WIDTH-1]);
        sign_in    = alu_result[WIDTH-1] ^ ovf;
      end
      default: begin
        alu_addsub = OP_ADD;
        a_sel      = a;
        ovf        = 1'b0;
        sign_in    = a[WIDTH-1];
      end
    endcase
  end

  // Shifting {s, A', Q, Q-1} right by one drops the old Q-1
  assign a_next  = {sign_in, a_sel[WIDTH-1:1]};
  assign q_next  = {a_sel[0], q[WIDTH-1:1]};
  assign q1_next = q[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for the radix-2 Booth signed multiplier. Owns the
// A/Q/Q-1/M registers and the bit counter, drives the shared add/sub ALU once
// per cycle and hands the {A,Q} product back over a valid/ready handshake.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_addsub,
  input  logic [WIDTH-1:0]   alu_result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic             q1;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;
  logic             q1_next;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a          (a),
    .q          (q),
    .q1         (q1),
    .m          (m),
    .alu_result (alu_result),
    .a_next     (a_next),
    .q_next     (q_next),
    .q1_next    (q1_next),
    .alu_addsub (alu_addsub)
  );

  // Controller FSM plus datapath registers: load on accept, one Booth step per
  // RUN cycle, hold the product in DONE until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a     <= '0;
      q     <= '0;
      q1    <= 1'b0;
      m     <= '0;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a     <= '0;
            q     <= multiplier;
            q1    <= 1'b0;
            m     <= multiplicand;
            count <= CNT_W'(WIDTH);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a     <= a_next;
          q     <= q_next;
          q1    <= q1_next;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign out_valid = (state == S_DONE);
  assign product   = {a, q};
  assign alu_a     = a;
  assign alu_b     = m;

endmodule
